// File: rtl/mbist_pkg.sv
// Shared MBIST/MBISR constants.
// Default geometry for the fail log and the spare-row base used by repair.
package mbist_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;
  localparam int PTR_W          = $clog2(DEF_DEPTH) + 1;

  // First spare row address handed to the MBISR stage
  localparam logic [DEF_ADDR_WIDTH-1:0] SPARE_BASE = 8'hF0;

endpackage

// File: rtl/fail_log_match.sv
// Parallel duplicate compare of an incoming fail address.
// Only entries below the write pointer take part in the match.
module fail_log_match
  import mbist_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int PW         = $clog2(DEPTH) + 1
) (
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] mem,
  input  logic [PW-1:0]                    wr_ptr,
  output logic                             hit
);

  logic [DEPTH-1:0] match;

  // One equality compare per slot, masked by occupancy
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign match[i] = (PW'(i) < wr_ptr) &&
                      (mem[i] == addr);
  end

  assign hit = |match;

endmodule

// File: rtl/fail_addr_log.sv
// Append-only fail-address log feeding the repair allocator.
// Define FAIL_LOG_DEDUP_EN to drop addresses already logged since clear.
module fail_addr_log
  import mbist_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int PW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [PW-1:0]         count,
  output logic [PW-1:0]         logged,
  output logic                  overflow
);

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] mem;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-2:0] wr_idx;
  logic [PW-2:0] rd_idx;
  logic          hit;
  logic          full;
  logic          push;
  logic          drop;
  logic          pop;
  logic          flush;

`ifdef FAIL_LOG_DEDUP_EN
  fail_log_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .PW         (PW)
  ) u_match (
    .addr   (in_addr),
    .mem    (mem),
    .wr_ptr (wr_ptr),
    .hit    (hit)
  );
`else
  assign hit = 1'b0;
`endif

  assign wr_idx = wr_ptr[PW-2:0];
  assign rd_idx = rd_ptr[PW-2:0];
  assign flush  = rst || clear;
  assign full   = (wr_ptr == PW'(DEPTH));
  assign push   = in_valid && !hit && !full;
  assign drop   = in_valid && !hit && full;

  // Pointers are monotonic, so empty is simply equality
  assign out_valid = (rd_ptr != wr_ptr);
  assign pop       = out_valid && out_ready;
  assign out_addr  = out_valid ? mem[rd_idx] : '0;
  assign count     = wr_ptr - rd_ptr;
  assign logged    = wr_ptr;

  // Storage; contents are irrelevant past wr_ptr so no reset
  always_ff @(posedge clk) begin
    if (!flush && push)
      mem[wr_idx] <= in_addr;
  end

  // Pointer and sticky overflow state; flush beats any strobe or pop
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (drop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fail_addr_log.sv
// Self-checking bench for fail_addr_log.
// Table vectors, directed corner sequences, then random vs a queue model.
module tb_fail_addr_log;

  localparam int AW = 8;
  localparam int D  = 16;
  localparam int PW = $clog2(D) + 1;

`ifdef FAIL_LOG_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          in_valid;
  logic [AW-1:0] in_addr;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [PW-1:0] count;
  logic [PW-1:0] logged;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  fail_addr_log dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .count     (count),
    .logged    (logged),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          clr;
    logic          iv;
    logic [AW-1:0] a;
    logic          rdy;
    int            e_cnt;
    int            e_log;
    logic          e_v;
    logic [AW-1:0] e_a;
    logic          e_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int c, input int l,
                         input logic v, input logic [AW-1:0] a,
                         input logic o);
    chk({nm, ".count"}, int'(count), c);
    chk({nm, ".logged"}, int'(logged), l);
    chk({nm, ".valid"}, int'(out_valid), int'(v));
    chk({nm, ".addr"}, int'(out_addr), int'(a));
    chk({nm, ".ovf"}, int'(overflow), int'(o));
  endtask

  // Drive one cycle of inputs, clock it, sample 1 time unit later
  task automatic step(input logic c, input logic iv,
                      input logic [AW-1:0] a, input logic rdy);
    clear     = c;
    in_valid  = iv;
    in_addr   = a;
    out_ready = rdy;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic fill16();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < D; i++)
      step(1'b0, 1'b1, AW'(i), 1'b0);
  endtask

  // Reference model: ordered list of logged addresses plus read index
  logic [AW-1:0] mq[$];
  int            mrd;
  logic          movf;

  task automatic model_step(input logic c, input logic iv,
                            input logic [AW-1:0] a, input logic rdy);
    bit dup;
    bit popn;
    if (c) begin
      mq.delete();
      mrd  = 0;
      movf = 1'b0;
      return;
    end
    popn = (mrd < mq.size()) && rdy;
    dup  = 1'b0;
    if (DEDUP)
      foreach (mq[k])
        if (mq[k] == a) dup = 1'b1;
    if (iv && !dup) begin
      if (mq.size() < D) mq.push_back(a);
      else movf = 1'b1;
    end
    if (popn) mrd++;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
    in_addr = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_all("reset", 0, 0, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;

    vecs[0] = '{1'b0, 1'b1, 8'h12, 1'b0, 1, 1, 1'b1, 8'h12, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h34, 1'b0, 2, 2, 1'b1, 8'h12, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h56, 1'b0, 3, 3, 1'b1, 8'h12, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 2, 3, 1'b1, 8'h34, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 3, 1'b1, 8'h56, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 3, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 3, 1'b0, 8'h00, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 8'h12, 1'b1, 0, 0, 1'b0, 8'h00, 1'b0};
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].clr, vecs[i].iv, vecs[i].a, vecs[i].rdy);
      chk_all($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_log,
              vecs[i].e_v, vecs[i].e_a, vecs[i].e_ovf);
    end

    // Hold: out_addr stable while not ready
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("hold.addr", int'(out_addr), 8'hA5);

    // Repeated address: back-to-back, then after pop
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h40, 1'b0);
    step(1'b0, 1'b1, 8'h40, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h40, 1'b0);
    if (DEDUP) chk_all("dup", 0, 1, 1'b0, 8'h00, 1'b0);
    else       chk_all("dup", 2, 3, 1'b1, 8'h40, 1'b0);

    // Duplicate arriving while full
    fill16();
    chk_all("full", 16, 16, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h05, 1'b0);
    chk("full_dup.ovf", int'(overflow), DEDUP ? 0 : 1);
    chk("full_dup.log", int'(logged), 16);

    // Unique address while full
    fill16();
    step(1'b0, 1'b1, 8'h20, 1'b0);
    chk_all("ovf", 16, 16, 1'b1, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h05, 1'b0);
    chk_all("ovf_dup", 16, 16, 1'b1, 8'h00, 1'b1);

    // Clear takes priority over a same-cycle strobe
    step(1'b1, 1'b1, 8'h99, 1'b1);
    chk_all("clr_pri", 0, 0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk_all("clr_pri2", 0, 0, 1'b0, 8'h00, 1'b0);

    // Simultaneous append and pop
    step(1'b0, 1'b1, 8'h11, 1'b0);
    step(1'b0, 1'b1, 8'h77, 1'b1);
    chk_all("simul", 1, 2, 1'b1, 8'h77, 1'b0);

    // Mid-run reset behaves as clear
    fill16();
    step(1'b0, 1'b1, 8'h21, 1'b1);
    rst = 1'b1;
    step(1'b0, 1'b1, 8'h33, 1'b1);
    rst = 1'b0;
    chk_all("midrst", 0, 0, 1'b0, 8'h00, 1'b0);

    // Randomized run against the queue model
    step(1'b1, 1'b0, 8'h00, 1'b0);
    mq.delete(); mrd = 0; movf = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic c, iv, r, rr;
      logic [AW-1:0] a;
      rr = ($urandom_range(0, 199) == 0);
      c  = ($urandom_range(0, 59) == 0);
      iv = ($urandom_range(0, 2) != 0);
      a  = AW'($urandom_range(0, 23));
      r  = ($urandom_range(0, 3) != 0);
      rst = rr;
      step(c, iv, a, r);
      rst = 1'b0;
      model_step(c || rr, iv, a, r);
      chk_all($sformatf("rnd%0d", n), mq.size() - mrd, mq.size(),
              mrd < mq.size(),
              (mrd < mq.size()) ? mq[mrd] : 8'h00, movf);
      if (bad > 20) break;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
